// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - Shared glyph table, FSM states and sizing helper for the segment monitor
package seg_pkg;

    // Index i holds the lit-segment pattern (bit0=a .. bit6=g) of hex digit i.
    localparam logic [15:0][6:0] GLYPHS = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    typedef enum logic {
        ST_WAIT  = 1'b0,
        ST_TRACK = 1'b1
    } state_t;

    function automatic int stab_w(input int stable);
        return $clog2(stable + 1);
    endfunction

endpackage

// File: rtl/seg7_to_hex.sv
// rtl/seg7_to_hex.sv - Combinational 7-segment pattern to hex digit decoder
module seg7_to_hex
    import seg_pkg::*;
(
    input  logic [6:0] pat_i,
    output logic       valid_o,
    output logic [3:0] value_o
);

    always_comb begin
        valid_o = 1'b0;
        value_o = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (pat_i == GLYPHS[i]) begin
                valid_o = 1'b1;
                value_o = 4'(i);
            end
        end
    end

endmodule

// File: rtl/seg_monitor.sv
// rtl/seg_monitor.sv - Glitch-filtering 7-segment receiver with mod-N sequence checker
module seg_monitor
    import seg_pkg::*;
#(
    parameter int MODULO = 5,
    parameter int STABLE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg,
    output logic [3:0] digit,
    output logic       digit_vld,
    output logic       sym_err,
    output logic       seq_err,
    output logic       locked,
    output logic [7:0] err_cnt
);

    localparam int                STAB_W    = stab_w(STABLE);
    localparam logic [STAB_W-1:0] STAB_MAX  = STAB_W'(STABLE);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE - 1);
    localparam logic [4:0]        MOD5      = 5'(MODULO);

    logic [6:0]        seg_q, cand_q, last_pat_q;
    logic [STAB_W-1:0] stab_q;
    state_t            state_q;
    logic [3:0]        digit_q;
    logic              digit_vld_q, sym_err_q, seq_err_q;
    logic [7:0]        err_cnt_q;

    logic       dec_valid;
    logic [3:0] dec_value;
    logic       accept;
    logic       out_of_range;
    logic [4:0] exp_next;
    logic       in_seq;
    logic       err_evt;

    seg7_to_hex u_dec (
        .pat_i   (cand_q),
        .valid_o (dec_valid),
        .value_o (dec_value)
    );

    // A held pattern is accepted once, on the last filter cycle, and only if it differs from the previous one.
    assign accept       = (seg_q == cand_q) && (stab_q == STAB_LAST) && (cand_q != last_pat_q);
    assign out_of_range = {1'b0, dec_value} >= MOD5;
    assign exp_next     = 5'(({1'b0, digit_q} + 5'd1) % MOD5);
    assign in_seq       = {1'b0, dec_value} == exp_next;
    assign err_evt      = accept && (!dec_valid || out_of_range ||
                                     ((state_q == ST_TRACK) && !in_seq));

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q       <= 7'h00;
            cand_q      <= 7'h00;
            stab_q      <= '0;
            last_pat_q  <= 7'h00;
            state_q     <= ST_WAIT;
            digit_q     <= 4'd0;
            digit_vld_q <= 1'b0;
            sym_err_q   <= 1'b0;
            seq_err_q   <= 1'b0;
            err_cnt_q   <= 8'd0;
        end else begin
            seg_q       <= seg;
            digit_vld_q <= 1'b0;
            sym_err_q   <= 1'b0;
            seq_err_q   <= 1'b0;

            if (seg_q != cand_q) begin
                cand_q <= seg_q;
                stab_q <= '0;
            end else if (stab_q < STAB_MAX) begin
                stab_q <= stab_q + 1'b1;
            end

            if (accept) begin
                last_pat_q <= cand_q;
                if (!dec_valid) begin
                    sym_err_q <= 1'b1;
                    state_q   <= ST_WAIT;
                end else if (out_of_range) begin
                    seq_err_q <= 1'b1;
                    digit_q   <= dec_value;
                    state_q   <= ST_WAIT;
                end else if (state_q == ST_WAIT) begin
                    digit_vld_q <= 1'b1;
                    digit_q     <= dec_value;
                    state_q     <= ST_TRACK;
                end else begin
                    // Out-of-sequence digits still resync the tracker.
                    digit_vld_q <= 1'b1;
                    digit_q     <= dec_value;
                    seq_err_q   <= !in_seq;
                end
            end

            if (err_evt && (err_cnt_q != 8'hFF)) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

    assign digit     = digit_q;
    assign digit_vld = digit_vld_q;
    assign sym_err   = sym_err_q;
    assign seq_err   = seq_err_q;
    assign locked    = (state_q == ST_TRACK);
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_seg_monitor.sv
// tb/tb_seg_monitor.sv - Directed self-checking bench for seg_monitor
module tb_seg_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] seg = 7'h00;
    logic [3:0] digit;
    logic       digit_vld, sym_err, seq_err, locked;
    logic [7:0] err_cnt;

    logic       rst1 = 1'b1;
    logic [6:0] seg1 = 7'h00;
    logic [3:0] digit1;
    logic       digit_vld1, sym_err1, seq_err1, locked1;
    logic [7:0] err_cnt1;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic       vld;
        logic       sym;
        logic       seq;
        logic       lck;
        logic [3:0] dig;
        logic [7:0] cnt;
    } ev_t;
    ev_t evq[$];

    always #5 clk = ~clk;

    seg_monitor u0 (
        .clk(clk), .rst(rst), .seg(seg), .digit(digit), .digit_vld(digit_vld),
        .sym_err(sym_err), .seq_err(seq_err), .locked(locked), .err_cnt(err_cnt)
    );

    seg_monitor #(.MODULO(5), .STABLE(1)) u1 (
        .clk(clk), .rst(rst1), .seg(seg1), .digit(digit1), .digit_vld(digit_vld1),
        .sym_err(sym_err1), .seq_err(seq_err1), .locked(locked1), .err_cnt(err_cnt1)
    );

    always @(negedge clk) begin
        if (digit_vld || sym_err || seq_err) begin
            evq.push_back('{vld: digit_vld, sym: sym_err, seq: seq_err,
                            lck: locked, dig: digit, cnt: err_cnt});
        end
    end

    task automatic hold(input logic [6:0] p, input int n);
        seg = p;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        seg = 7'h00;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({digit, digit_vld, sym_err, seq_err, locked, err_cnt} !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_outputs: got dig=%0d vld=%b sym=%b seq=%b lck=%b cnt=%0d, want all 0",
                     digit, digit_vld, sym_err, seq_err, locked, err_cnt);
        end
        @(posedge clk); #1;
        evq.delete();
        hold(7'h00, 12);
        tests_run++;
        if (evq.size() != 0) begin
            tests_failed++;
            $display("FAIL reset_blank_silent: got %0d events, want 0", evq.size());
        end
    endtask

    task automatic test_clean_count;
        logic [6:0] pats [7] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h3F, 7'h06};
        logic [3:0] exp  [7] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd1};
        evq.delete();
        for (int i = 0; i < 7; i++) hold(pats[i], 10);
        tests_run++;
        if (evq.size() != 7) begin
            tests_failed++;
            $display("FAIL clean_event_count: got %0d, want 7", evq.size());
        end
        for (int i = 0; i < 7 && i < evq.size(); i++) begin
            tests_run++;
            if (!(evq[i].vld === 1'b1 && evq[i].sym === 1'b0 && evq[i].seq === 1'b0 &&
                  evq[i].dig === exp[i] && evq[i].lck === 1'b1)) begin
                tests_failed++;
                $display("FAIL clean_event_%0d: got vld=%b sym=%b seq=%b dig=%0d lck=%b, want vld=1 sym=0 seq=0 dig=%0d lck=1",
                         i, evq[i].vld, evq[i].sym, evq[i].seq, evq[i].dig, evq[i].lck, exp[i]);
            end
        end
        tests_run++;
        if (locked !== 1'b1 || err_cnt !== 8'd0) begin
            tests_failed++;
            $display("FAIL clean_final: got lck=%b cnt=%0d, want lck=1 cnt=0", locked, err_cnt);
        end
    endtask

    task automatic test_glitch;
        evq.delete();
        hold(7'h06, 5);
        hold(7'h07, 3);
        hold(7'h06, 12);
        tests_run++;
        if (evq.size() != 0) begin
            tests_failed++;
            $display("FAIL glitch_short_run: got %0d events, want 0", evq.size());
        end
        hold(7'h5B, 5);
        hold(7'h4F, 10);
        tests_run++;
        if (evq.size() != 2) begin
            tests_failed++;
            $display("FAIL glitch_long_run_count: got %0d events, want 2", evq.size());
        end else begin
            tests_run++;
            if (!(evq[0].vld === 1'b1 && evq[0].dig === 4'd2 && evq[0].seq === 1'b0 && evq[0].sym === 1'b0)) begin
                tests_failed++;
                $display("FAIL glitch_long_run_digit: got vld=%b dig=%0d seq=%b sym=%b, want vld=1 dig=2 no err",
                         evq[0].vld, evq[0].dig, evq[0].seq, evq[0].sym);
            end
        end
    endtask

    task automatic test_seq_err;
        hold(7'h66, 10);
        hold(7'h3F, 10);
        hold(7'h06, 10);
        evq.delete();
        hold(7'h66, 10);
        tests_run++;
        if (evq.size() != 1 || !(evq[0].vld === 1'b1 && evq[0].seq === 1'b1 && evq[0].sym === 1'b0 &&
                                 evq[0].dig === 4'd4 && evq[0].cnt === 8'd1 && evq[0].lck === 1'b1)) begin
            tests_failed++;
            $display("FAIL seq_err_event: got n=%0d vld=%b seq=%b dig=%0d cnt=%0d lck=%b, want n=1 vld=1 seq=1 dig=4 cnt=1 lck=1",
                     evq.size(), evq[0].vld, evq[0].seq, evq[0].dig, evq[0].cnt, evq[0].lck);
        end
        evq.delete();
        hold(7'h3F, 10);
        tests_run++;
        if (evq.size() != 1 || !(evq[0].vld === 1'b1 && evq[0].seq === 1'b0 && evq[0].dig === 4'd0 &&
                                 evq[0].cnt === 8'd1)) begin
            tests_failed++;
            $display("FAIL seq_resync: got n=%0d vld=%b seq=%b dig=%0d cnt=%0d, want n=1 vld=1 seq=0 dig=0 cnt=1",
                     evq.size(), evq[0].vld, evq[0].seq, evq[0].dig, evq[0].cnt);
        end
    endtask

    task automatic test_sym_range;
        evq.delete();
        hold(7'h49, 10);
        hold(7'h7D, 10);
        hold(7'h3F, 10);
        tests_run++;
        if (evq.size() != 3) begin
            tests_failed++;
            $display("FAIL symrange_count: got %0d events, want 3", evq.size());
        end else begin
            tests_run++;
            if (!(evq[0].sym === 1'b1 && evq[0].vld === 1'b0 && evq[0].seq === 1'b0 &&
                  evq[0].lck === 1'b0 && evq[0].dig === 4'd0 && evq[0].cnt === 8'd2)) begin
                tests_failed++;
                $display("FAIL sym_err_event: got sym=%b vld=%b lck=%b dig=%0d cnt=%0d, want sym=1 vld=0 lck=0 dig=0 cnt=2",
                         evq[0].sym, evq[0].vld, evq[0].lck, evq[0].dig, evq[0].cnt);
            end
            tests_run++;
            if (!(evq[1].seq === 1'b1 && evq[1].vld === 1'b0 && evq[1].sym === 1'b0 &&
                  evq[1].lck === 1'b0 && evq[1].dig === 4'd6 && evq[1].cnt === 8'd3)) begin
                tests_failed++;
                $display("FAIL range_err_event: got seq=%b vld=%b lck=%b dig=%0d cnt=%0d, want seq=1 vld=0 lck=0 dig=6 cnt=3",
                         evq[1].seq, evq[1].vld, evq[1].lck, evq[1].dig, evq[1].cnt);
            end
            tests_run++;
            if (!(evq[2].vld === 1'b1 && evq[2].seq === 1'b0 && evq[2].lck === 1'b1 &&
                  evq[2].dig === 4'd0 && evq[2].cnt === 8'd3)) begin
                tests_failed++;
                $display("FAIL relock_event: got vld=%b seq=%b lck=%b dig=%0d cnt=%0d, want vld=1 seq=0 lck=1 dig=0 cnt=3",
                         evq[2].vld, evq[2].seq, evq[2].lck, evq[2].dig, evq[2].cnt);
            end
        end
    endtask

    task automatic test_saturation_and_reset;
        int nsym;
        evq.delete();
        for (int i = 0; i < 300; i++) hold((i % 2 == 0) ? 7'h49 : 7'h01, 6);
        repeat (3) @(posedge clk);
        #1;
        nsym = 0;
        foreach (evq[i]) if (evq[i].sym === 1'b1) nsym++;
        tests_run++;
        if (nsym != 300) begin
            tests_failed++;
            $display("FAIL sat_sym_events: got %0d, want 300", nsym);
        end
        tests_run++;
        if (err_cnt !== 8'd255) begin
            tests_failed++;
            $display("FAIL sat_err_cnt: got %0d, want 255", err_cnt);
        end
        hold(7'h3F, 2);
        rst = 1'b1;
        seg = 7'h00;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({digit, digit_vld, sym_err, seq_err, locked, err_cnt} !== 16'h0000) begin
            tests_failed++;
            $display("FAIL midfilter_reset: got dig=%0d vld=%b sym=%b seq=%b lck=%b cnt=%0d, want all 0",
                     digit, digit_vld, sym_err, seq_err, locked, err_cnt);
        end
        @(posedge clk); #1;
        evq.delete();
        hold(7'h00, 12);
        tests_run++;
        if (evq.size() != 0) begin
            tests_failed++;
            $display("FAIL post_reset_blank: got %0d events, want 0", evq.size());
        end
    endtask

    task automatic test_latency_default;
        seg = 7'h3F;
        repeat (5) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (digit_vld !== 1'b0) begin
            tests_failed++;
            $display("FAIL lat4_early: got vld=%b after edge k+4, want 0", digit_vld);
        end
        @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (digit_vld !== 1'b1 || digit !== 4'd0) begin
            tests_failed++;
            $display("FAIL lat4_accept: got vld=%b dig=%0d after edge k+5, want vld=1 dig=0", digit_vld, digit);
        end
        @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (digit_vld !== 1'b0) begin
            tests_failed++;
            $display("FAIL lat4_pulse_width: got vld=%b after edge k+6, want 0", digit_vld);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_stable1;
        rst1 = 1'b0;
        seg1 = 7'h00;
        repeat (3) @(posedge clk);
        #1;
        seg1 = 7'h06;
        @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (digit_vld1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL lat1_early: got vld=%b after edge k, want 0", digit_vld1);
        end
        @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (digit_vld1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL lat1_k1: got vld=%b after edge k+1, want 0", digit_vld1);
        end
        @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (digit_vld1 !== 1'b1 || digit1 !== 4'd1 || locked1 !== 1'b1) begin
            tests_failed++;
            $display("FAIL lat1_accept: got vld=%b dig=%0d lck=%b after edge k+2, want vld=1 dig=1 lck=1",
                     digit_vld1, digit1, locked1);
        end
        @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (digit_vld1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL lat1_pulse_width: got vld=%b after edge k+3, want 0", digit_vld1);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_clean_count();
        test_glitch();
        test_seq_err();
        test_sym_range();
        test_saturation_and_reset();
        test_latency_default();
        test_stable1();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/seg_monitor.md
# seg_monitor

Receiving end of the counter's 7-segment display interface. Samples a 7-segment pattern bus, filters the glitches that ripple counters produce, and decodes each stable pattern back to a 4-bit digit. It checks that successive digits follow the count sequence modulo `MODULO` and reports symbol and sequence errors. It sits beside the mod-N counter/display path as an in-system checker and for bench self-checking.

## Interface
- `MODULO`, default 5: expected count modulus; legal range 2..16.
- `STABLE`, default 4: number of extra consecutive cycles a pattern must hold before it is accepted; legal range ≥1.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `seg` input, 7 bits: segment pattern. bit0=a … bit6=g, 1 = segment lit. May be asynchronous/glitchy.
- `digit` output, 4 bits: last accepted decoded digit.
- `digit_vld` output, 1 bit: one-cycle pulse when a valid in-range digit is accepted.
- `sym_err` output, 1 bit: one-cycle pulse when an accepted pattern is not a hex glyph.
- `seq_err` output, 1 bit: one-cycle pulse on an out-of-sequence or out-of-range digit.
- `locked` output, 1 bit: high while tracking a sequence.
- `err_cnt` output, 8 bits: saturating count of `sym_err` plus `seq_err` events.

## Operation
- **Glyphs** (hex, pattern for digits 0..F): 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71. Any other pattern, including 00 (blank), is invalid.
- **Input stage:** `seg_q <= seg` every cycle.
- **Filter:**
  - If `seg_q != cand`: `cand <= seg_q`, `stab <= 0`.
  - Else if `stab < STABLE`: `stab <= stab+1`.
- **Accept event:** `seg_q == cand` and `stab == STABLE-1` and `cand != last_pat`. On accept, `last_pat <= cand`.
  - A run shorter than the filter window is discarded.
  - A glitch that returns to the previously accepted pattern produces no event.
- **FSM states:** WAIT (reset state, `locked=0`) and TRACK (`locked=1`).
- **On accept, in order of priority:**
  - Invalid glyph: `sym_err` pulses; go to WAIT; `digit` unchanged.
  - Decoded value ≥ `MODULO`: `seq_err` pulses; `digit` updated; go to WAIT.
  - In WAIT: `digit_vld` pulses; `digit` updated; go to TRACK; no sequence check.
  - In TRACK with value == (`digit`+1) mod `MODULO`: `digit_vld` pulses; `digit` updated.
  - In TRACK with any other value: `digit_vld` and `seq_err` both pulse; `digit` updated (resync); stay in TRACK.
- **Error counter:** `err_cnt` increments on `sym_err` or `seq_err` and saturates at 255. At most one increment per cycle.
- **Arithmetic:** all arithmetic is unsigned. The (`digit`+1) mod `MODULO` wrap is computed at 5-bit width.

## Timing
- **Reset values:**
  - Internal: `seg_q`=00, `cand`=00, `stab`=0, `last_pat`=00, state WAIT.
  - Outputs: `digit`=0, all pulses 0, `locked`=0, `err_cnt`=0.
- **Reset during blank input:** a blank `seg` held through and after reset is silent, because `cand == last_pat`.
- **Latency:** a pattern first sampled at edge k and held constant is accepted at edge k+STABLE+1. Its outputs are visible in the following cycle.
  - Example: `STABLE`=4 gives acceptance 5 edges after first sampling.
- **Pulse spacing:** pulses last exactly one cycle. Minimum spacing between accept events is STABLE+1 cycles.
- **Reset mid-filter:** `rst` asserted mid-filter or mid-pulse wins. Outputs read reset values after that edge.
- **Change during final cycle:** a pattern change on the cycle `stab` would reach `STABLE-1` cancels the accept and restarts the filter.

## Structure
- **Package `seg_pkg`:**
  - The 16 glyph constants.
  - The state enum {WAIT, TRACK}.
  - A `STAB_W` helper equal to clog2(STABLE+1).
- **Sub-module `seg7_to_hex`:** combinational, pattern → {valid, value[3:0]}, the inverse of the display encoder. Reusable elsewhere.
- **Top level:** the input register, filter, FSM and counters stay in `seg_monitor`. Expected size is about 150-250 lines.

## Test plan
- **Clean count:** defaults; drive 3F,06,5B,4F,66,3F,06, each held 10 cycles. Required: 7 `digit_vld` pulses with digits 0,1,2,3,4,0,1; `locked`=1 after the first; `err_cnt`=0.
- **Glitch rejection:** hold 06, insert 07 for 3 cycles, return to 06. Required: no pulse of any kind.
  - Insert 5B for 5 cycles instead: exactly one `digit_vld` with digit 2.
- **Sequence error:** in TRACK after digit 1, present 66 (4). Required: `digit_vld` and `seq_err` in the same cycle; `digit`=4; `err_cnt`=1; `locked` stays 1.
  - Then 3F (0): clean `digit_vld`, no error.
- **Symbol and range errors:**
  - Present 49: `sym_err`, `locked`=0, `digit` unchanged.
  - Then 7D (6, ≥ `MODULO`): `seq_err`, `digit`=6, `locked`=0.
  - Then 3F: `digit_vld`, `locked`=1.
  - `err_cnt`=2.
- **Saturation and reset:** force 300 alternating invalid patterns (49, 01), each held ≥6 cycles. Required: `err_cnt`=255.
  - Assert `rst` one cycle mid-filter: all outputs at reset values on the next cycle.
  - Blank `seg` after reset: no pulse.
- **`STABLE`=1 latency check:** pattern first sampled at edge k. Required: `digit_vld` asserted after edge k+2.
